// File: rtl/fifo_word_packer.sv
// Packs RATIO consecutive WIDTH-bit FIFO entries (LSB lane first) into one output word
// behind a valid/ready slot; a flush pulse emits the partial word with a lane-keep mask.

module fifo_word_packer_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)   q <= '0;
        else if (we) q <= din;
    end
endmodule

module fifo_word_packer #(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int RATIO_l = $clog2(RATIO)
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   fifo_rd,
    input  logic [WIDTH-1:0]       fifo_dout,
    input  logic                   fifo_empty,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]       out_keep,
    output logic                   busy
);
    typedef enum logic [1:0] {FILL, HOLD, FLUSH} state_t;

    localparam logic [RATIO_l:0] IDX_FULL = (RATIO_l+1)'(RATIO);
    localparam logic [RATIO_l:0] IDX_ONE  = (RATIO_l+1)'(1);

    state_t                        state, state_d;
    logic [RATIO_l:0]              idx, idx_d;
    logic                          rd_pend, flush_req, flush_req_d;
    logic                          cap, cap_last, slot_free, load;
    logic [RATIO_l-1:0]            lane_sel;
    logic [RATIO-1:0]              lane_we, part_keep, load_keep;
    logic [RATIO-1:0][WIDTH-1:0]   pbuf, full_word, part_word, load_data;

    assign lane_sel  = idx[RATIO_l-1:0];
    assign cap       = (state == FILL) && rd_pend;
    assign cap_last  = cap && (lane_sel == RATIO_l'(RATIO-1));
    assign slot_free = !out_valid || out_ready;

    // Count the in-flight read so the last lane's data lands before another read issues.
    assign fifo_rd = !reset && !fifo_empty && (state == FILL) && !flush_req &&
                     ((idx + (RATIO_l+1)'(rd_pend)) < IDX_FULL);

    assign busy = (idx != '0) || rd_pend || out_valid || flush_req || (state != FILL);

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        assign lane_we[k]   = cap && (lane_sel == RATIO_l'(k));
        assign part_keep[k] = idx > (RATIO_l+1)'(k);
        assign part_word[k] = part_keep[k] ? pbuf[k] : '0;
        // The completing lane is still on fifo_dout, so bypass it into the outgoing word.
        assign full_word[k] = (cap_last && k == RATIO-1) ? fifo_dout : pbuf[k];

        fifo_word_packer_lane #(.WIDTH(WIDTH)) u_lane (
            .clock (clock),
            .reset (reset),
            .we    (lane_we[k]),
            .din   (fifo_dout),
            .q     (pbuf[k])
        );
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        flush_req_d = flush_req || flush;
        load        = 1'b0;
        load_data   = full_word;
        load_keep   = '1;
        case (state)
            FILL: begin
                if (rd_pend) begin
                    idx_d = idx + IDX_ONE;
                    if (cap_last) begin
                        if (slot_free) begin
                            load  = 1'b1;
                            idx_d = '0;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end else if (flush_req) begin
                    state_d = FLUSH;
                end
            end
            HOLD: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = pbuf;
                    idx_d     = '0;
                    state_d   = FILL;
                end
            end
            FLUSH: begin
                if (idx == '0) begin
                    flush_req_d = 1'b0;
                    state_d     = FILL;
                end else if (slot_free) begin
                    load        = 1'b1;
                    load_data   = part_word;
                    load_keep   = part_keep;
                    idx_d       = '0;
                    flush_req_d = 1'b0;
                    state_d     = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            idx       <= '0;
            rd_pend   <= 1'b0;
            flush_req <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            rd_pend   <= fifo_rd;
            flush_req <= flush_req_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the single-clock FIFO. Reads WIDTH-bit entries via the FIFO's rd/dout/empty interface.
- Packs RATIO consecutive entries, LSB-first, into one WIDTH*RATIO word.
- Presents packed words on a valid/ready output. A flush input emits a partial word with a lane-keep mask.

Parameters:
- WIDTH, 8, entry width; must match the upstream FIFO WIDTH.
- RATIO, 4, entries per output word; power of two, at least 2.
- RATIO_l, $clog2(RATIO), lane index width.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- fifo_rd  out  1  read strobe to the FIFO `rd` input.
- fifo_dout  in  WIDTH  FIFO `dout`.
- fifo_empty  in  1  FIFO `empty`.
- flush  in  1  single-cycle pulse: emit the partial word.
- out_valid  out  1  packed word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WIDTH*RATIO  packed word; lane k is bits [k*WIDTH +: WIDTH].
- out_keep  out  RATIO  bit k set when lane k holds real data.
- busy  out  1  any data in flight or held.

Behaviour:
- Reset (asynchronous, active-high):
  - fifo_rd=0, out_valid=0, out_data=0, out_keep=0, busy=0.
  - Internal state cleared: idx=0, rd_pend=0, flush_req=0, state=FILL.
  - Reset mid-word discards all partial and pending data. Nothing is emitted after reset deasserts.
- Upstream contract: FIFO read latency is 1. Data for a read issued in cycle t is captured from fifo_dout at the posedge ending cycle t+1.
  - rd_pend is fifo_rd registered.
  - fifo_rd is never asserted while fifo_empty=1, so every strobe is a real read.
- fifo_rd is combinational:
  - fifo_rd = !fifo_empty && state==FILL && !flush_req && (idx + rd_pend) < RATIO.
- Capture: when rd_pend=1, lane idx of the pack buffer is loaded with fifo_dout and idx increments.
- Word completion (lane RATIO-1 written):
  - If the output slot is free (out_valid=0, or out_valid && out_ready this cycle), the word loads into the output register with out_keep all ones, and idx returns to 0.
  - Otherwise state goes to HOLD with the pack buffer full.
- HOLD:
  - No reads issued.
  - When the slot frees, the pack buffer transfers to the output register, idx=0, state returns to FILL.
- Throughput: at most RATIO entries per RATIO+1 cycles. There is one bubble per word because the last-lane read must land before the next read issues.
- Output handshake:
  - out_valid stays high and out_data/out_keep stay stable until out_valid && out_ready.
  - A new word may load in the same cycle as a transfer.
- Flush:
  - A flush pulse sets flush_req, which blocks new reads.
  - Once rd_pend=0, state goes to FLUSH.
  - FLUSH with 0<idx<RATIO: when the slot is free, emit lanes 0..idx-1, unused lanes zero, out_keep = (1<<idx)-1. Then idx=0, flush_req=0, state returns to FILL.
  - FLUSH with idx==0: nothing is emitted and flush_req clears next cycle.
  - A flush arriving in HOLD: the full word emits normally with keep all ones, then flush proceeds with idx=0.
  - A flush while flush_req is already set is absorbed.
- busy = (idx!=0) || rd_pend || out_valid || flush_req || state!=FILL.
- Order is strictly preserved: entry N of the FIFO lands in word N/RATIO, lane N%RATIO.
- idx width is RATIO_l+1, so the value RATIO is representable. Lane select uses idx[RATIO_l-1:0].

Test Plan:
- Reset: assert reset for 10 cycles mid-traffic -> fifo_rd, out_valid, out_keep, busy all 0 immediately (asynchronous). No word is emitted after release.
- Streaming, upstream FIFO DEPTH=16 WIDTH=8, out_ready=1: write 0x01..0x08 -> exactly two words, 0x04030201 then 0x08070605, out_keep=4'hF. busy=0 afterwards and FIFO empty.
- Backpressure: out_ready=0, write 12 entries 0x10..0x1B ->
  - out_data=0x13121110 held stable.
  - Pack buffer reaches HOLD with 0x17161514.
  - fifo_rd stays 0 and the FIFO retains 4 entries.
  - Raising out_ready yields 0x13121110, 0x17161514, 0x1B1A1918 in order.
- Partial flush: write 0xAA, 0xBB, 0xCC, then pulse flush after the captures -> one word 0x00CCBBAA with out_keep=4'b0111. A following 4-entry burst packs from lane 0.
- Flush races: a flush pulse with idx=0 -> no output and busy drops within 2 cycles. A flush pulse in the same cycle as fifo_rd -> the pending entry is captured before the partial word emits, and no entry is lost.
- Randomized mix: random wr bursts, random out_ready and occasional flush -> a scoreboard confirms every written byte appears once in order, and each out_keep matches the lane count.
